// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART/cycle-counter MMIO slave: register offsets,
// status bit positions, FSM state types and baud divisor helper.
package uart_mmio_pkg;

    localparam int unsigned IO_BASE_BIT = 31;

    localparam logic [7:0] UART_STATUS = 8'h00;
    localparam logic [7:0] UART_RX     = 8'h04;
    localparam logic [7:0] UART_TX     = 8'h08;
    localparam logic [7:0] CYCLE_CNT   = 8'h10;
    localparam logic [7:0] CNT_RESET   = 8'h18;

    localparam int unsigned ST_TX_READY  = 0;
    localparam int unsigned ST_RX_VALID  = 1;
    localparam int unsigned ST_FRAME_ERR = 2;
    localparam int unsigned ST_OVERRUN   = 3;

    localparam int unsigned TX_FRAME_BITS = 10;
    localparam int unsigned RX_DATA_BITS  = 8;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned symbol_edge_time(input int unsigned clk_hz,
                                                     input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_mmio_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit qualification at half symbol,
// centre sampling of data and stop bits; one-cycle data_valid / frame_err pulses.
module uart_rx #(
    parameter int unsigned SYMBOL_EDGE_TIME = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err
);
    import uart_mmio_pkg::*;

    localparam int unsigned CNT_W = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SYMBOL_EDGE_TIME / 2 - 1);
    localparam logic [2:0] LAST_DATA_BIT   = 3'(RX_DATA_BITS - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Line idles high; resetting the synchronizer high avoids a false start edge.
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                sym_cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (sym_cnt_q == HALF_LAST) begin
                    sym_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sym_cnt_q == SYM_LAST) begin
                    sym_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (sym_cnt_q == SYM_LAST) begin
                    sym_cnt_d = '0;
                    state_d   = RX_IDLE;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_mmio.sv
// MMIO slave for the memory stage: UART TX/RX registers and a free-running cycle
// counter at addr[31]=1, decoded on addr[7:0], with registered 1-cycle read data.
module uart_mmio #(
    parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        FPGA_SERIAL_RX,
    output logic        FPGA_SERIAL_TX
);
    import uart_mmio_pkg::*;

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CPU_CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0] TX_LAST_BIT    = 4'(TX_FRAME_BITS - 1);

    logic       sel, rd_en, wr_en;
    logic [7:0] offset;
    logic       st_rd, rx_rd, tx_wr, cnt_clr;
    logic       unused_bits;

    assign sel     = addr[IO_BASE_BIT];
    assign offset  = addr[7:0];
    assign rd_en   = sel && re;
    assign wr_en   = sel && (|we);
    assign st_rd   = rd_en && (offset == UART_STATUS);
    assign rx_rd   = rd_en && (offset == UART_RX);
    assign tx_wr   = wr_en && (offset == UART_TX);
    assign cnt_clr = wr_en && (offset == CNT_RESET);
    assign unused_bits = ^{addr[30:8], wdata[31:8]};

    // ---------------- TX serializer ----------------
    tx_state_e                  tx_state_q, tx_state_d;
    logic [TX_FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [3:0]                 tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0]           tx_sym_q, tx_sym_d;
    logic                       tx_out_q, tx_out_d;
    logic                       tx_ready;

    assign tx_ready = (tx_state_q == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_sym_q   <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_sym_q   <= tx_sym_d;
            tx_out_q   <= tx_out_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_sym_d   = tx_sym_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_d = TX_SEND;
                    tx_shift_d = {1'b1, wdata[7:0], 1'b0};
                    tx_bit_d   = '0;
                    tx_sym_d   = '0;
                end
            end
            TX_SEND: begin
                if (tx_sym_q == SYM_LAST) begin
                    tx_sym_d = '0;
                    if (tx_bit_q == TX_LAST_BIT) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b1, tx_shift_q[TX_FRAME_BITS-1:1]};
                    end
                end else begin
                    tx_sym_d = tx_sym_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Output is registered from next-state so the line is glitch-free.
        tx_out_d = (tx_state_d == TX_SEND) ? tx_shift_d[0] : 1'b1;
    end

    assign FPGA_SERIAL_TX = tx_out_q;

    // ---------------- RX and flags ----------------
    logic [7:0] rx_byte;
    logic       rx_byte_valid, rx_frame_err;

    uart_rx #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (FPGA_SERIAL_RX),
        .data_out   (rx_byte),
        .data_valid (rx_byte_valid),
        .frame_err  (rx_frame_err)
    );

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Sets are applied after clears so a completing event is never lost to a read.
    always_comb begin
        rx_data_d   = rx_byte_valid ? rx_byte : rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (rx_rd) begin
            rx_valid_d = 1'b0;
        end
        if (st_rd) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (rx_byte_valid) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_rd) begin
                overrun_d = 1'b1;
            end
        end
        if (rx_frame_err) begin
            frame_err_d = 1'b1;
        end
    end

    // ---------------- Cycle counter ----------------
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        cycle_cnt_d = cnt_clr ? '0 : cycle_cnt_q + 32'd1;
    end

    // ---------------- Read path ----------------
    logic [31:0] status;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        status               = '0;
        status[ST_TX_READY]  = tx_ready;
        status[ST_RX_VALID]  = rx_valid_q;
        status[ST_FRAME_ERR] = frame_err_q;
        status[ST_OVERRUN]   = overrun_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (offset)
                UART_STATUS: rdata_d = status;
                UART_RX:     rdata_d = {24'd0, rx_data_q};
                CYCLE_CNT:   rdata_d = cycle_cnt_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
